memory_stage_cached: RTL

MEMORY_STAGE_CACHED -- requirements
Module: memory_stage_cached

---
 rtl/memory_stage_cached_pkg.sv | 21 ++
 rtl/memory_stage_cached_dcache_array.sv | 71 +++++++
 rtl/memory_stage_cached.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_cached_pkg.sv
// Shared encodings for the cached memory stage:
// load/store size codes, writeback select and cache FSM states.
package memory_stage_cached_pkg;

  localparam logic [2:0] MOP_LB  = 3'b000;
  localparam logic [2:0] MOP_LH  = 3'b001;
  localparam logic [2:0] MOP_LW  = 3'b010;
  localparam logic [2:0] MOP_LBU = 3'b100;
  localparam logic [2:0] MOP_LHU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    STORE
  } dstate_e;

endpackage

// File: rtl/memory_stage_cached_dcache_array.sv
// Direct-mapped tag/valid/data store, one word per line.
// Lookup is combinational; fills and store merges land on the clock edge.
module dcache_array
  import memory_stage_cached_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic [DATA_WIDTH-1:2]   raddr_i,
  output logic                    hit_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic                    fill_i,
  input  logic                    store_i,
  input  logic [DATA_WIDTH-1:2]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i
);

  localparam int IW = $clog2(SETS);
  localparam int TW = DATA_WIDTH - 2 - IW;
  localparam int NB = DATA_WIDTH / 8;

  logic [SETS-1:0]       valid_q;
  logic [TW-1:0]         tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  logic [IW-1:0]         ridx, widx;
  logic [TW-1:0]         rtag, wtag;
  logic                  whit;
  logic [DATA_WIDTH-1:0] merged;

  assign ridx = raddr_i[2 +: IW];
  assign rtag = raddr_i[DATA_WIDTH-1 -: TW];
  assign widx = waddr_i[2 +: IW];
  assign wtag = waddr_i[DATA_WIDTH-1 -: TW];

  assign hit_o   = valid_q[ridx] && (tag_q[ridx] == rtag);
  assign rdata_o = data_q[ridx];
  assign whit    = valid_q[widx] && (tag_q[widx] == wtag);

  always_comb begin
    merged = data_q[widx];
    for (int b = 0; b < NB; b++) begin
      if (wstrb_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // Stores never allocate: only a line already holding the tag is merged.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata_i;
    end else if (store_i && whit) begin
      data_q[widx] <= merged;
    end
  end

endmodule

// File: rtl/memory_stage_cached.sv
// Memory stage with a direct-mapped write-through data cache
// and the M->W pipeline register.
module memory_stage_cached
  import memory_stage_cached_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    RegWriteM,
  input  logic [1:0]              ResultSrcM,
  input  logic                    MemWriteM,
  input  logic                    MemReadM,
  input  logic [2:0]              MemoryOpM,
  input  logic [4:0]              RdM,
  input  logic [DATA_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  input  logic [DATA_WIDTH-1:0]   PCPlus4M,
  output logic [DATA_WIDTH-1:0]   ReadDataM,
  output logic                    MemStall,
  output logic                    RegWriteW,
  output logic [4:0]              RdW,
  output logic [DATA_WIDTH-1:0]   ResultW,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    cache_flush
);

  localparam int NB = DATA_WIDTH / 8;

  dstate_e               state_q;
  logic                  mem_req_q, mem_we_q;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_wdata_q;
  logic [NB-1:0]         mem_wstrb_q;
  logic                  st_done_q, flush_pend_q;

  logic                  regw_q;
  logic [1:0]            rsrc_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] alu_q, rdat_q, pc4_q;

  logic                  hit;
  logic [DATA_WIDTH-1:0] line, lane, st_data, fill_data;
  logic [NB-1:0]         st_strb;
  logic [1:0]            off;
  logic                  ld_miss, st_go, fill, st_wr, flush_now;

  assign off  = ALUResultM[1:0];
  assign lane = line >> {off, 3'b000};

  always_comb begin
    ReadDataM = lane;
    unique case (1'b1)
      MemoryOpM == MOP_LB:
        ReadDataM = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      MemoryOpM == MOP_LH:
        ReadDataM = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      MemoryOpM == MOP_LBU:
        ReadDataM = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      MemoryOpM == MOP_LHU:
        ReadDataM = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      MemoryOpM == MOP_LW:
        ReadDataM = line;
      default:
        ReadDataM = lane;
    endcase
  end

  always_comb begin
    st_data = WriteDataM;
    st_strb = '1;
    unique case (1'b1)
      MemoryOpM[1:0] == 2'b00: begin
        st_data = {NB{WriteDataM[7:0]}};
        st_strb = {{(NB-1){1'b0}}, 1'b1} << off;
      end
      MemoryOpM[1:0] == 2'b01: begin
        st_data = {(NB/2){WriteDataM[15:0]}};
        st_strb = {{(NB-2){1'b0}}, 2'b11} << off;
      end
      default: ;
    endcase
  end

  // st_done_q keeps a frozen store from being reissued once acked.
  assign ld_miss   = (state_q == IDLE) && MemReadM && !hit;
  assign st_go     = (state_q == IDLE) && MemWriteM && !st_done_q;
  assign fill      = (state_q == REFILL) && mem_ack;
  assign st_wr     = (state_q == STORE) && mem_ack;
  assign flush_now = (state_q == IDLE) && (cache_flush || flush_pend_q);
  assign fill_data = fill ? mem_rdata : mem_wdata_q;

  assign MemStall  = !reset && ((state_q != IDLE) || ld_miss || st_go);

  dcache_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .SETS      (SETS)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .flush_i(flush_now),
    .raddr_i(ALUResultM[DATA_WIDTH-1:2]),
    .hit_o  (hit),
    .rdata_o(line),
    .fill_i (fill),
    .store_i(st_wr),
    .waddr_i(mem_addr_q[DATA_WIDTH-1:2]),
    .wdata_i(fill_data),
    .wstrb_i(mem_wstrb_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      st_done_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (state_q != IDLE && cache_flush) flush_pend_q <= 1'b1;
      else if (flush_now)                 flush_pend_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!stall) st_done_q <= 1'b0;
          if (ld_miss) begin
            state_q     <= REFILL;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end else if (st_go) begin
            state_q     <= STORE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_q <= st_data;
            mem_wstrb_q <= st_strb;
          end
        end
        REFILL, STORE: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            st_done_q <= (state_q == STORE);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regw_q <= 1'b0;
      rsrc_q <= '0;
      rd_q   <= '0;
      alu_q  <= '0;
      rdat_q <= '0;
      pc4_q  <= '0;
    end else if (stall) begin
      regw_q <= regw_q;
    end else if (MemStall) begin
      regw_q <= 1'b0;
      rsrc_q <= '0;
      rd_q   <= '0;
      alu_q  <= '0;
      rdat_q <= '0;
      pc4_q  <= '0;
    end else begin
      regw_q <= RegWriteM;
      rsrc_q <= ResultSrcM;
      rd_q   <= RdM;
      alu_q  <= ALUResultM;
      rdat_q <= ReadDataM;
      pc4_q  <= PCPlus4M;
    end
  end

  assign RegWriteW = regw_q;
  assign RdW       = rd_q;

  always_comb begin
    ResultW = '0;
    unique case (1'b1)
      rsrc_q == RES_ALU: ResultW = alu_q;
      rsrc_q == RES_MEM: ResultW = rdat_q;
      rsrc_q == RES_PC4: ResultW = pc4_q;
      default:           ResultW = '0;
    endcase
  end

endmodule
